// File: rtl/tb_periph_pkg.sv
`default_nettype none
// =============================================================================
// Package : tb_periph_pkg
// Register offsets, magic values and response codes for the TB peripheral.
// Rev     : 1.0
// =============================================================================
package tb_periph_pkg;

  localparam logic [3:0]  OFF_PRINT  = 4'h0;
  localparam logic [3:0]  OFF_STATUS = 4'h4;
  localparam logic [3:0]  OFF_EXIT   = 4'h8;
  localparam logic [3:0]  OFF_CYCLES = 4'hC;

  localparam logic [31:0] PASS_MAGIC = 32'h075B_CD15;
  localparam logic [31:0] FAIL_MAGIC = 32'h0000_0001;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_PRINT  = 3'd0,
    SEL_STATUS = 3'd1,
    SEL_EXIT   = 3'd2,
    SEL_CYCLES = 3'd3,
    SEL_MISS   = 3'd4
  } reg_sel_e;

  typedef struct packed {
    logic [1:0] resp;
    logic       print;
    logic       set_pass;
    logic       set_fail;
    logic       exit_wr;
  } wr_effect_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_tb_periph.sv
`default_nettype none
// =============================================================================
// Module : axi_lite_tb_periph
// AXI4-Lite responder for the stdout/status/exit/cycle-counter TB registers.
// Rev    : 1.0
// =============================================================================
module axi_lite_tb_periph
  import tb_periph_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
  input  logic                  s_awvalid_i,
  output logic                  s_awready_o,

  input  logic [31:0]           s_wdata_i,
  input  logic [3:0]            s_wstrb_i,
  input  logic                  s_wvalid_i,
  output logic                  s_wready_o,

  output logic [1:0]            s_bresp_o,
  output logic                  s_bvalid_o,
  input  logic                  s_bready_i,

  input  logic [ADDR_WIDTH-1:0] s_araddr_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,

  output logic [31:0]           s_rdata_o,
  output logic [1:0]            s_rresp_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,

  output logic [7:0]            print_wdata_o,
  output logic                  print_valid_o,
  output logic                  tests_passed_o,
  output logic                  tests_failed_o,
  output logic [31:0]           exit_value_o,
  output logic                  exit_valid_o
);

  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] addr);
    reg_sel_e sel;
    sel = SEL_MISS;
    if (addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]) begin
      case (addr[3:0])
        OFF_PRINT:  sel = SEL_PRINT;
        OFF_STATUS: sel = SEL_STATUS;
        OFF_EXIT:   sel = SEL_EXIT;
        OFF_CYCLES: sel = SEL_CYCLES;
        default:    sel = SEL_MISS;
      endcase
    end
    return sel;
  endfunction

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic                  r_aw_full;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic                  r_w_full;
  logic [31:0]           r_w_data;
  logic [3:0]            r_w_strb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [7:0]            r_print_data;
  logic                  r_print_valid;
  logic                  r_passed;
  logic                  r_failed;
  logic [31:0]           r_exit_value;
  logic                  r_exit_valid;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [31:0]           w_wr_data;
  logic [3:0]            w_wr_strb;
  wr_effect_t            w_eff;

  assign s_awready_o = !rst_i && !r_aw_full && !r_bvalid;
  assign s_wready_o  = !rst_i && !r_w_full  && !r_bvalid;
  assign w_aw_hs     = s_awvalid_i && s_awready_o;
  assign w_w_hs      = s_wvalid_i  && s_wready_o;
  assign w_commit    = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);

  // A channel that handshakes in the commit cycle bypasses its holding slot.
  assign w_wr_addr = r_aw_full ? r_aw_addr : s_awaddr_i;
  assign w_wr_data = r_w_full  ? r_w_data  : s_wdata_i;
  assign w_wr_strb = r_w_full  ? r_w_strb  : s_wstrb_i;

  always_comb begin
    w_eff      = '0;
    w_eff.resp = RESP_OKAY;
    case (decode(w_wr_addr))
      SEL_PRINT: w_eff.print = w_wr_strb[0];
      SEL_STATUS: begin
        if (w_wr_strb == 4'hF) begin
          w_eff.set_pass = (w_wr_data == PASS_MAGIC);
          w_eff.set_fail = (w_wr_data == FAIL_MAGIC);
        end else begin
          w_eff.resp = RESP_SLVERR;
        end
      end
      SEL_EXIT: begin
        if (w_wr_strb == 4'hF) w_eff.exit_wr = 1'b1;
        else                   w_eff.resp    = RESP_SLVERR;
      end
      default: w_eff.resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_full     <= 1'b0;
      r_aw_addr     <= '0;
      r_w_full      <= 1'b0;
      r_w_data      <= '0;
      r_w_strb      <= '0;
      r_bvalid      <= 1'b0;
      r_bresp       <= RESP_OKAY;
      r_print_data  <= '0;
      r_print_valid <= 1'b0;
      r_passed      <= 1'b0;
      r_failed      <= 1'b0;
      r_exit_value  <= '0;
      r_exit_valid  <= 1'b0;
    end else begin
      r_print_valid <= 1'b0;
      if (r_bvalid && s_bready_i) r_bvalid <= 1'b0;

      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_eff.resp;
        if (w_eff.print) begin
          r_print_valid <= 1'b1;
          r_print_data  <= w_wr_data[7:0];
        end
        if (w_eff.set_pass) r_passed <= 1'b1;
        if (w_eff.set_fail) r_failed <= 1'b1;
        if (w_eff.exit_wr) begin
          r_exit_value <= w_wr_data;
          r_exit_valid <= 1'b1;
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_full <= 1'b1;
          r_aw_addr <= s_awaddr_i;
        end
        if (w_w_hs) begin
          r_w_full <= 1'b1;
          r_w_data <= s_wdata_i;
          r_w_strb <= s_wstrb_i;
        end
      end
    end
  end

  assign s_bvalid_o     = r_bvalid;
  assign s_bresp_o      = r_bresp;
  assign print_wdata_o  = r_print_data;
  assign print_valid_o  = r_print_valid;
  assign tests_passed_o = r_passed;
  assign tests_failed_o = r_failed;
  assign exit_value_o   = r_exit_value;
  assign exit_valid_o   = r_exit_valid;

  // ---------------------------------------------------------------------------
  // Read path and cycle counter
  // ---------------------------------------------------------------------------
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [31:0] r_cycles;

  logic        w_ar_hs;
  logic [31:0] w_rd_data;
  logic [1:0]  w_rd_resp;

  assign s_arready_o = !rst_i && !r_rvalid;
  assign w_ar_hs     = s_arvalid_i && s_arready_o;

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    case (decode(s_araddr_i))
      SEL_PRINT:  w_rd_data = '0;
      SEL_STATUS: w_rd_data = {30'b0, r_failed, r_passed};
      SEL_EXIT:   w_rd_data = r_exit_value;
      SEL_CYCLES: w_rd_data = r_cycles;
      default:    w_rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_cycles <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_resp;
      end else if (r_rvalid && s_rready_i) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_rvalid_o = r_rvalid;
  assign s_rdata_o  = r_rdata;
  assign s_rresp_o  = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_tb_periph.sv
`default_nettype none
// =============================================================================
// Module : tb_axi_lite_tb_periph
// Scoreboard bench for axi_lite_tb_periph using directed register accesses.
// Rev    : 1.0
// =============================================================================
module tb_axi_lite_tb_periph;
  import tb_periph_pkg::*;

  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  print_wdata;
  logic        print_valid, passed, failed, exit_valid;
  logic [31:0] exit_value;

  always #5 clk = ~clk;

  axi_lite_tb_periph #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_awaddr_i(awaddr), .s_awvalid_i(awvalid), .s_awready_o(awready),
    .s_wdata_i(wdata), .s_wstrb_i(wstrb), .s_wvalid_i(wvalid), .s_wready_o(wready),
    .s_bresp_o(bresp), .s_bvalid_o(bvalid), .s_bready_i(bready),
    .s_araddr_i(araddr), .s_arvalid_i(arvalid), .s_arready_o(arready),
    .s_rdata_o(rdata), .s_rresp_o(rresp), .s_rvalid_o(rvalid), .s_rready_i(rready),
    .print_wdata_o(print_wdata), .print_valid_o(print_valid),
    .tests_passed_o(passed), .tests_failed_o(failed),
    .exit_value_o(exit_value), .exit_valid_o(exit_valid)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        chk_data;
  } rexp_t;

  int          total = 0;
  int          bad = 0;
  int          print_count = 0;
  logic [1:0]  exp_b[$];
  rexp_t       exp_r[$];
  rexp_t       r_e;
  logic [31:0] cyc0, cyc1, pc_snap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every B / R handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (print_valid) print_count++;
      if (bvalid && bready) begin
        total++;
        if (exp_b.size() == 0) begin
          bad++;
          $display("FAIL b_unexpected: actual bresp=%h required=no response", bresp);
        end else if (bresp !== exp_b[0]) begin
          bad++;
          $display("FAIL bresp: actual=%h required=%h", bresp, exp_b[0]);
        end
        if (exp_b.size() != 0) void'(exp_b.pop_front());
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          total++;
          bad++;
          $display("FAIL r_unexpected: actual rdata=%h required=no response", rdata);
        end else begin
          r_e = exp_r.pop_front();
          check("rresp", {30'b0, rresp}, {30'b0, r_e.resp});
          if (r_e.chk_data) check("rdata", rdata, r_e.data);
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] resp, input string name);
    bit aw_d = 0, w_d = 0;
    int n = 0;
    exp_b.push_back(resp);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    while (!(aw_d && w_d) && n < 20) begin
      @(negedge clk);
      if (awvalid && awready) aw_d = 1;
      if (wvalid && wready) w_d = 1;
      @(posedge clk); #1;
      if (aw_d) awvalid = 1'b0;
      if (w_d)  wvalid  = 1'b0;
      n++;
    end
    if (!(aw_d && w_d)) begin
      total++; bad++;
      $display("FAIL %s_handshake: actual=timeout after %0d cycles required=AW and W accepted", name, n);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    @(negedge clk);
    check({name, "_b_latency"}, {31'b0, bvalid}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic chk,
                         input logic [1:0] resp, input string name);
    bit ar_d = 0;
    int n = 0;
    exp_r.push_back('{data, resp, chk});
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (!ar_d && n < 20) begin
      @(negedge clk);
      if (arready) ar_d = 1;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 1'b0;
    if (!ar_d) begin
      total++; bad++;
      $display("FAIL %s_handshake: actual=timeout after %0d cycles required=AR accepted", name, n);
    end
    @(negedge clk);
    check({name, "_r_latency"}, {31'b0, rvalid}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_bvalid"}, {31'b0, bvalid}, 32'd0);
    check({name, "_rvalid"}, {31'b0, rvalid}, 32'd0);
    check({name, "_resps"}, {28'b0, bresp, rresp}, 32'd0);
    check({name, "_rdata"}, rdata, 32'd0);
    check({name, "_print"}, {23'b0, print_valid, print_wdata}, 32'd0);
    check({name, "_flags"}, {29'b0, exit_valid, failed, passed}, 32'd0);
    check({name, "_exit_value"}, exit_value, 32'd0);
  endtask

  initial begin
    // Reset: readies low during reset, high right after.
    repeat (2) @(negedge clk);
    check("rst_readies_low", {29'b0, awready, wready, arready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_readies_high", {29'b0, awready, wready, arready}, 32'h7);
    check_idle("rst");
    @(posedge clk); #1;

    // PRINT with AW and W three cycles apart, bready held low.
    awaddr = BASE; awvalid = 1'b1; wdata = 32'h41; wstrb = 4'h1; bready = 1'b0;
    exp_b.push_back(RESP_OKAY);
    @(negedge clk); check("t1_awready", {31'b0, awready}, 32'd1);
    @(posedge clk); #1 awvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t1_no_early_commit", {30'b0, print_valid, bvalid}, 32'd0);
      @(posedge clk); #1;
    end
    wvalid = 1'b1;
    @(negedge clk); check("t1_wready", {31'b0, wready}, 32'd1);
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk);
    check("t1_print_pulse", {23'b0, print_valid, print_wdata}, 32'h141);
    check("t1_bvalid", {31'b0, bvalid}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_print_once", {31'b0, print_valid}, 32'd0);
      check("t1_b_hold", {29'b0, bvalid, awready, wready}, 32'h4);
    end
    @(posedge clk); #1 bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_b_done", {30'b0, bvalid, awready}, 32'h1);
    @(posedge clk); #1;

    // STATUS
    do_write(BASE + 32'h4, PASS_MAGIC, 4'hF, RESP_OKAY, "st_pass");
    check("st_passed", {30'b0, failed, passed}, 32'h1);
    do_read(BASE + 32'h4, 32'h1, 1'b1, RESP_OKAY, "st_rd1");
    do_write(BASE + 32'h4, FAIL_MAGIC, 4'hF, RESP_OKAY, "st_fail");
    do_read(BASE + 32'h4, 32'h3, 1'b1, RESP_OKAY, "st_rd3");
    do_write(BASE + 32'h4, 32'h5, 4'hF, RESP_OKAY, "st_other");
    do_read(BASE + 32'h4, 32'h3, 1'b1, RESP_OKAY, "st_rd3b");
    check("st_flags", {30'b0, failed, passed}, 32'h3);

    // EXIT
    do_write(BASE + 32'h8, 32'h0, 4'hF, RESP_OKAY, "ex0");
    check("ex0_state", {exit_valid, exit_value[30:0]}, 32'h8000_0000);
    do_write(BASE + 32'h8, 32'h7, 4'hF, RESP_OKAY, "ex7");
    check("ex7_value", exit_value, 32'h7);
    check("ex7_valid", {31'b0, exit_valid}, 32'd1);
    do_read(BASE + 32'h8, 32'h7, 1'b1, RESP_OKAY, "ex_rd");

    // Error and no-effect writes
    pc_snap = print_count;
    do_write(BASE + 32'h10, 32'h42, 4'hF, RESP_SLVERR, "err_miss");
    do_write(BASE + 32'h2, 32'h43, 4'h1, RESP_SLVERR, "err_misal");
    do_write(BASE + 32'h8, 32'h99, 4'h3, RESP_SLVERR, "err_strb");
    do_write(BASE + 32'hC, 32'h5, 4'hF, RESP_SLVERR, "err_cycles");
    do_write(BASE + 32'h4, PASS_MAGIC, 4'h7, RESP_SLVERR, "err_st_strb");
    do_write(BASE, 32'h44, 4'h2, RESP_OKAY, "pr_nostrb");
    check("err_no_print", print_count, pc_snap);
    check("err_exit_kept", exit_value, 32'h7);
    check("err_flags_kept", {29'b0, exit_valid, failed, passed}, 32'h7);
    do_read(BASE + 32'h14, 32'h0, 1'b1, RESP_SLVERR, "rd_miss");
    do_read(BASE, 32'h0, 1'b1, RESP_OKAY, "rd_print");

    // CYCLES: AR handshakes exactly 10 cycles apart
    exp_r.push_back('{32'h0, RESP_OKAY, 1'b0});
    exp_r.push_back('{32'h0, RESP_OKAY, 1'b0});
    araddr = BASE + 32'hC; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk); check("cyc_arready0", {31'b0, arready}, 32'd1);
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk); cyc0 = rdata;
    check("cyc_rvalid0", {31'b0, rvalid}, 32'd1);
    repeat (9) @(posedge clk);
    #1 arvalid = 1'b1;
    @(negedge clk); check("cyc_arready1", {31'b0, arready}, 32'd1);
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk); cyc1 = rdata;
    check("cyc_rvalid1", {31'b0, rvalid}, 32'd1);
    check("cyc_delta", cyc1 - cyc0, 32'd10);
    @(posedge clk); #1;

    // Concurrent EXIT write and EXIT read: read sees the old value
    fork
      do_write(BASE + 32'h8, 32'h55, 4'hF, RESP_OKAY, "cc_w");
      do_read(BASE + 32'h8, 32'h7, 1'b1, RESP_OKAY, "cc_r");
    join
    check("cc_exit_new", exit_value, 32'h55);

    // Reset with a pending B response
    awaddr = BASE; awvalid = 1'b1; wdata = 32'h5A; wstrb = 4'h1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk); check("rp_bvalid_pending", {31'b0, bvalid}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    exp_b.delete();
    @(negedge clk); check("rp_readies_low", {29'b0, awready, wready, arready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check_idle("rp");
    @(posedge clk); #1 rst = 1'b0; bready = 1'b1;

    // Reset with only the AW slot full: a later lone W must not commit
    awaddr = BASE + 32'h8; awvalid = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk);
    check("ra_no_commit", {30'b0, bvalid, exit_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    do_write(BASE + 32'h8, 32'h3C, 4'hF, RESP_OKAY, "fresh");
    check("fresh_exit", {exit_valid, exit_value[30:0]}, 32'h8000_003C);
    do_read(BASE + 32'h4, 32'h0, 1'b1, RESP_OKAY, "fresh_status");

    repeat (3) @(posedge clk);
    check("drain_b", exp_b.size(), 32'd0);
    check("drain_r", exp_r.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_tb_periph.md
# axi_lite_tb_periph

AXI4-Lite responder implementing the testbench pseudo-peripherals: stdout character port, pass/fail status, exit code, and a free-running cycle counter. Sits on the core's data-side AXI4-Lite interconnect inside the AXI subsystem. Its outputs drive the top-level print, tests-passed/failed and exit signals that the simulation top monitors to print characters and end the run.

## Interface
- `ADDR_WIDTH`, default 32: AXI address width.
- `BASE_ADDR`, default 32'h1000_0000: 16-byte-aligned base of the register window.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `s_awaddr_i` in ADDR_WIDTH, `s_awvalid_i` in 1, `s_awready_o` out 1: write address channel.
- `s_wdata_i` in 32, `s_wstrb_i` in 4, `s_wvalid_i` in 1, `s_wready_o` out 1: write data channel.
- `s_bresp_o` out 2, `s_bvalid_o` out 1, `s_bready_i` in 1: write response channel.
- `s_araddr_i` in ADDR_WIDTH, `s_arvalid_i` in 1, `s_arready_o` out 1: read address channel.
- `s_rdata_o` out 32, `s_rresp_o` out 2, `s_rvalid_o` out 1, `s_rready_i` in 1: read data channel.
- `print_wdata_o`  out  8  character to print.
- `print_valid_o`  out  1  one-cycle strobe that qualifies `print_wdata_o`.
- `tests_passed_o`  out  1  sticky pass flag.
- `tests_failed_o`  out  1  sticky fail flag.
- `exit_value_o`  out  32  last written exit code.
- `exit_valid_o`  out  1  sticky; set by the first EXIT write.

## Operation
- Register map (offsets from BASE_ADDR):
  - 0x0 PRINT: write only; reads return 0.
  - 0x4 STATUS: write; reads return {30'b0, failed, passed}.
  - 0x8 EXIT: read/write.
  - 0xC CYCLES: read only; 32-bit counter, wraps.
- Decode: hit requires addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4] and addr[1:0] == 0.
- Decode miss: resp SLVERR (2'b10), no side effect. Reads that miss return rdata 0.
- Writes to CYCLES: SLVERR, no effect.
- PRINT: if wstrb[0], print_wdata_o = wdata[7:0] and print_valid_o pulses. If wstrb[0]=0, no effect, resp OKAY.
- STATUS and EXIT require wstrb == 4'hF; otherwise SLVERR and no effect.
- STATUS write of 32'h075B_CD15 sets passed; write of 32'h1 sets failed; any other value gives OKAY with no effect. Both flags may be set; neither clears except by reset.
- EXIT write latches exit_value_o and sets exit_valid_o. Later EXIT writes update the value; valid stays 1.
- Write path: independent AW and W holding slots.
  - awready = !aw_full && !bvalid; wready = !w_full && !bvalid.
  - Once both slots are full, or fill in the same cycle, the write commits.
- Read path: arready = !rvalid. Data is captured at the AR handshake and held stable until the R handshake.
- Read and write paths are fully independent. A simultaneous read of EXIT and write to EXIT returns the old value.

## Timing
- Reset values: every ready = 0 during reset and 1 in the first cycle after reset. bvalid/rvalid 0, bresp/rresp 0, rdata 0, print 0/0, flags 0, exit_value 0, exit_valid 0, counter 0.
- CYCLES increments every non-reset cycle.
- AW and W handshakes both done by cycle N (either order or the same cycle) → in cycle N+1:
  - bvalid = 1 with bresp;
  - print_valid_o pulse, flag set and exit update all become visible.
- bvalid holds until bready; awready/wready stay low while bvalid = 1. Sustained writes are at most one every 2 cycles.
- AR handshake at N → rvalid = 1 at N+1; holds with stable rdata/rresp until rready. Back-to-back reads are at most one every 2 cycles.
- CYCLES read returns the counter value at the AR handshake cycle.
- Reset asserted mid-transaction: slots and pending responses are dropped; all outputs return to reset values on the next edge.

## Structure
- Package `tb_periph_pkg` holds:
  - offsets OFF_PRINT/OFF_STATUS/OFF_EXIT/OFF_CYCLES;
  - PASS_MAGIC = 32'h075B_CD15 and FAIL_MAGIC = 32'h1;
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
- Single module, no sub-module; write and read paths are separate always_ff blocks.

## Test plan
- AW at cycle 5, W at cycle 8, PRINT, wdata 0x41, wstrb 4'h1 → print_valid_o = 1 and print_wdata_o = 0x41 only at cycle 9, bvalid at 9 with OKAY; bready held low 3 cycles → bvalid held and awready = 0 throughout.
- STATUS write 0x075BCD15, then a read of STATUS → tests_passed_o = 1, rdata = 0x1. Then write 0x1 → rdata = 0x3. Then write 0x5 → flags unchanged, OKAY.
- EXIT write 0x0 then 0x7 → exit_valid_o = 1 after the first write; exit_value_o = 0x7 after the second; read returns 0x7.
- Write to BASE_ADDR+0x10, misaligned write to BASE_ADDR+0x2, EXIT write with wstrb 4'h3, CYCLES write → each SLVERR; no output changes.
- Read CYCLES twice with AR handshakes 10 cycles apart → rdata difference = 10. Read issued concurrently with a write → both complete, each with 1-cycle latency.
- Reset asserted while bvalid pending and an AW slot is full → next cycle all outputs at reset values; a fresh write completes normally.
